// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Streams a length-prefixed, XOR-checksummed program into
//            instruction memory one 32-bit word at a time.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
   parameter int NumInst = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int          c_IW    = (NumInst > 1) ? $clog2(NumInst) : 1;
   localparam logic [16:0] c_MAX_N = 17'(NumInst);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CSUM   = 3'd5,
      S_FIN    = 3'd6
   } state_t;

   state_t          r_state;
   logic            r_byte_ready;
   logic            r_wr_en;
   logic            r_busy;
   logic            r_done;
   logic            r_error;
   logic [31:0]     r_wr_addr;
   logic [31:0]     r_wr_data;
   logic [15:0]     r_len;
   logic [23:0]     r_word;
   logic [1:0]      r_byte_cnt;
   logic [7:0]      r_csum;
   logic [c_IW-1:0] r_word_idx;

   logic        w_xfer;
   logic [15:0] w_len_full;
   logic        w_len_bad;
   logic        w_more;
   logic [31:0] w_addr_next;

   assign w_xfer      = byte_valid & r_byte_ready;
   assign w_len_full  = {byte_data, r_len[7:0]};
   assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > c_MAX_N);
   assign w_more      = ({{(17 - c_IW){1'b0}}, r_word_idx} + 17'd1) < {1'b0, r_len};
   assign w_addr_next = 32'({r_word_idx, 2'b00});

   // Outputs are registered: each transition also loads the flags of the state it enters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_byte_ready <= 1'b0;
         r_wr_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_wr_addr    <= 32'd0;
         r_wr_data    <= 32'd0;
         r_len        <= 16'd0;
         r_word       <= 24'd0;
         r_byte_cnt   <= 2'd0;
         r_csum       <= 8'd0;
         r_word_idx   <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_LEN_LO;
                  r_byte_ready <= 1'b1;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_error      <= 1'b0;
                  r_csum       <= 8'd0;
                  r_word_idx   <= '0;
                  r_byte_cnt   <= 2'd0;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= byte_data;
                  r_state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= byte_data;
                  if (w_len_bad) begin
                     r_error      <= 1'b1;
                     r_state      <= S_FIN;
                     r_byte_ready <= 1'b0;
                     r_busy       <= 1'b0;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_csum     <= r_csum ^ byte_data;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  case (r_byte_cnt)
                     2'd0: r_word[7:0]   <= byte_data;
                     2'd1: r_word[15:8]  <= byte_data;
                     2'd2: r_word[23:16] <= byte_data;
                     default: begin
                        r_state      <= S_WRITE;
                        r_byte_ready <= 1'b0;
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= w_addr_next;
                        r_wr_data    <= {byte_data, r_word};
                     end
                  endcase
               end
            end
            S_WRITE: begin
               r_byte_ready <= 1'b1;
               // The index only advances when another word follows, so it never reaches NumInst.
               if (w_more) begin
                  r_word_idx <= r_word_idx + c_IW'(1);
                  r_state    <= S_DATA;
               end else begin
                  r_state <= S_CSUM;
               end
            end
            S_CSUM: begin
               if (w_xfer) begin
                  if (byte_data == r_csum) begin
                     r_done <= 1'b1;
                  end else begin
                     r_error <= 1'b1;
                  end
                  r_state      <= S_FIN;
                  r_byte_ready <= 1'b0;
                  r_busy       <= 1'b0;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state      <= S_IDLE;
               r_byte_ready <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready = r_byte_ready;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;

endmodule
`default_nettype wire
